// File: rtl/mdiv_unit_if.sv
// Bus between the memory stage / hazard unit and the multiply/divide unit.
// The master launches operations and observes HI/LO/BUSY; the slave is mdiv_unit.
interface mdiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             EN;
    logic [2:0]       OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             KILL;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             BUSY;
    logic [1:0]       state_dbg;

    // EN is a one-cycle strobe with no back-pressure: the unit accepts every
    // EN it sees and reports an operation in flight through BUSY.
    modport master (output EN, OP, A, B, KILL, input HI, LO, BUSY, state_dbg);
    modport slave  (input EN, OP, A, B, KILL, output HI, LO, BUSY, state_dbg);
endinterface

// File: rtl/mdiv_unit.sv
// Iterative shift-add multiplier / restoring divider that owns the HI/LO pair.
// One iteration per clock in CALC, sign fix-up and HI/LO write in FIX.
module mdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic        CLK,
    input  logic        RESET_N,
    mdiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;

    logic               op_signed;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, mul_fix;
    logic [WIDTH-1:0]   rem_fix, quot_fix;

    // Magnitudes; the most negative value becomes unsigned 2^(WIDTH-1).
    assign op_signed = (bus.OP == OP_MULT) || (bus.OP == OP_DIV);
    assign a_abs     = (op_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign b_abs     = (op_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    // prod_q holds {upper, lower} for multiply and {rem, quot} for divide.
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};
    assign div_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opnd_q};
    assign div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};

    assign mul_fix  = neg_res_q ? -prod_q : prod_q;
    assign rem_fix  = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
    assign quot_fix = neg_res_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (bus.KILL) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                CALC: begin
                    prod_d = is_div_q ? div_next : mul_next;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) state_d = FIX;
                end
                FIX: begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = bzero_q ? '1 : quot_fix;
                    end else begin
                        {hi_d, lo_d} = mul_fix;
                    end
                    state_d = IDLE;
                end
                default: ;
            endcase
            // A new EN discards whatever the in-flight operation would have written.
            if (bus.EN) begin
                case (bus.OP)
                    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        state_d   = CALC;
                        cnt_d     = '0;
                        is_div_d  = bus.OP[1];
                        neg_res_d = op_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        neg_rem_d = op_signed & bus.A[WIDTH-1];
                        bzero_d   = (bus.B == '0);
                        prod_d    = {{WIDTH{1'b0}}, (bus.OP[1] ? a_abs : b_abs)};
                        opnd_d    = bus.OP[1] ? b_abs : a_abs;
                        hi_d      = hi_q;
                        lo_d      = lo_q;
                    end
                    OP_MTHI: begin
                        state_d = IDLE;
                        hi_d    = bus.A;
                        lo_d    = lo_q;
                    end
                    OP_MTLO: begin
                        state_d = IDLE;
                        hi_d    = hi_q;
                        lo_d    = bus.A;
                    end
                    default: ;
                endcase
            end
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prod_q    <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.HI        = hi_q;
    assign bus.LO        = lo_q;
    assign bus.BUSY      = busy_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_mdiv_unit.sv
// Bench for mdiv_unit: directed cases plus randomized launches, restarts,
// kills and resets checked by a scoreboard against an arithmetic model.
module tb_mdiv_unit;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic RESET_N = 1'b1;

  mdiv_unit_if #(.WIDTH(W)) bus();

  mdiv_unit #(.WIDTH(W)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  // Entry: {check_busy_length, hi, lo}
  logic [2*W:0] exp_q[$];
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;
  int n_pass = 0;
  int n_total = 0;
  int busy_cnt = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: plain integer arithmetic, result packed as {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sp;
    logic [63:0] up;
    int q, r;
    case (op)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      3'd1: begin
        up = {32'b0, a} * {32'b0, b};
        return up;
      end
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit use_given, input logic [63:0] given);
    logic [63:0] res;
    @(posedge CLK); #1;
    bus.EN = 1'b1; bus.OP = op; bus.A = a; bus.B = b;
    @(posedge CLK); #1;
    bus.EN = 1'b0; bus.A = $urandom; bus.B = $urandom; bus.OP = 3'($urandom_range(0, 7));
    if (op < 3'd6) begin
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      if (op < 3'd4) begin
        res = use_given ? given : ref_result(op, a, b);
        exp_q.push_back({1'b1, res});
        busy_cnt = 0;
      end else if (op == 3'd4) begin
        exp_q.push_back({1'b0, a, lo_m});
      end else begin
        exp_q.push_back({1'b0, hi_m, a});
      end
    end
  endtask

  task automatic kill(input bit en_too);
    @(posedge CLK); #1;
    bus.KILL = 1'b1;
    if (en_too) begin
      bus.EN = 1'b1; bus.OP = 3'($urandom_range(0, 5)); bus.A = $urandom; bus.B = $urandom;
    end
    @(posedge CLK); #1;
    bus.KILL = 1'b0; bus.EN = 1'b0;
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_back());
      exp_q.push_back({1'b0, hi_m, lo_m});
    end
  endtask

  task automatic reset_pulse();
    @(posedge CLK); #1;
    RESET_N = 1'b0;
    exp_q.delete();
    hi_m = '0;
    lo_m = '0;
    @(posedge CLK); #1;
    RESET_N = 1'b1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80 && exp_q.size() > 0; i++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL timeout: BUSY still %0d after 80 cycles, required 0", bus.BUSY);
      exp_q.delete();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    logic [2*W:0] e;
    if (mon_en) begin
      if (bus.BUSY) busy_cnt++;
      if (exp_q.size() > 0 && !bus.BUSY) begin
        e = exp_q.pop_front();
        check("hi_result", bus.HI, e[2*W-1:W]);
        check("lo_result", bus.LO, e[W-1:0]);
        if (e[2*W]) check("busy_len", 32'(busy_cnt), 32'd33);
        hi_m = e[2*W-1:W];
        lo_m = e[W-1:0];
      end else begin
        check("hi_hold", bus.HI, hi_m);
        check("lo_hold", bus.LO, lo_m);
        if (exp_q.size() == 0) check("busy_idle", {31'b0, bus.BUSY}, 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] op;
    logic [W-1:0] a, b;
    int sel;
    bus.EN = 1'b0; bus.OP = 3'd0; bus.A = '0; bus.B = '0; bus.KILL = 1'b0;
    #2 RESET_N = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;

    launch(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001);
    wait_done();
    launch(3'd0, 32'hFFFF_FFFD, 32'd7, 1, 64'hFFFF_FFFF_FFFF_FFEB);
    wait_done();
    launch(3'd2, 32'hFFFF_FFF9, 32'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_done();
    launch(3'd3, 32'd100, 32'd0, 1, {32'd100, 32'hFFFF_FFFF});
    wait_done();
    launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, {32'd0, 32'h8000_0000});
    wait_done();

    // Restart: the first multiply never writes.
    launch(3'd1, 32'd6, 32'd7, 0, 64'd0);
    repeat (3) @(posedge CLK);
    launch(3'd3, 32'd100, 32'd7, 1, {32'd2, 32'd14});
    wait_done();

    // MTLO aborts a multiply in flight.
    launch(3'd0, 32'h0BAD_F00D, 32'h1357_9BDF, 0, 64'd0);
    @(posedge CLK);
    launch(3'd5, 32'h0000_1234, 32'd0, 0, 64'd0);
    wait_done();

    // KILL mid-CALC, then KILL racing a simultaneous EN.
    launch(3'd0, 32'h7654_3210, 32'hFEDC_BA98, 0, 64'd0);
    repeat (18) @(posedge CLK);
    kill(1'b0);
    wait_done();
    launch(3'd2, 32'h1234_5678, 32'd9, 0, 64'd0);
    repeat (5) @(posedge CLK);
    kill(1'b1);
    wait_done();

    // MTHI while idle, then reset in the middle of CALC.
    launch(3'd4, 32'hCAFE_0001, 32'd0, 0, 64'd0);
    wait_done();
    launch(3'd1, 32'h0001_0001, 32'h0002_0003, 0, 64'd0);
    repeat (9) @(posedge CLK);
    reset_pulse();
    repeat (40) @(posedge CLK);

    for (int it = 0; it < 60; it++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 200); b = $urandom_range(1, 15); end
      else if (sel == 3) b = 32'hFFFF_FFFF;
      launch(op, a, b, 0, 64'd0);
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        repeat ($urandom_range(0, 35)) @(posedge CLK);
        kill($urandom_range(0, 1) == 1);
        wait_done();
      end else if (sel < 3) begin
        repeat ($urandom_range(0, 33)) @(posedge CLK);
      end else begin
        wait_done();
      end
    end
    wait_done();
    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mdiv_unit.md
# mdiv_unit

Iterative multiply/divide unit and HI/LO register owner for the integer pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the memory stage, runs one shift-add or restoring-divide step per clock, and writes HI/LO on completion. It drives BUSY, which the hazard unit combines with an mfhi/mflo in M to stall F/D and E/M.

## Interface
- WIDTH, 32: operand width; HI, LO are WIDTH each; iteration counter is clog2(WIDTH) bits.
- CLK  in  1  clock; all state updates on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- EN  in  1  single-cycle launch strobe for the instruction in M, already qualified against stall/flush.
- OP  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
- A  in  WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO source).
- B  in  WIDTH  rt operand (multiplier / divisor).
- KILL  in  1  exception flush: aborts an operation in flight.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.
- BUSY  out  1  registered; high whenever the state is not IDLE.

## Operation
- States: IDLE, CALC, FIX.
- Reset (async, any state): state=IDLE, HI=0, LO=0, BUSY=0, counter=0, internal registers=0.
- EN with OP 0–3, any state (including CALC/FIX): latch |A|, |B|, the sign flags, and the op; counter=0; state=CALC. An operation in flight is discarded without updating HI/LO.
- EN with OP 4/5, any state: HI=A (4) or LO=A (5); abort any operation in flight; state=IDLE.
- EN with OP 6/7: no effect.
- KILL: state=IDLE and HI/LO are unchanged. KILL has priority over a simultaneous EN.
- Magnitudes: signed ops take the two's-complement absolute value; 0x80000000 is treated as unsigned 2^31. Unsigned ops pass operands through unchanged.
- Multiply, in CALC, per cycle: the 2W product register starts as {0, |B|}. If bit 0 is set, add |A| to the upper half with a WIDTH+1-bit carry, then shift the whole register right by 1.
- Divide, in CALC, per cycle (restoring): shift {rem, quot} left by 1. Trial-subtract |B| from rem (WIDTH+1 bits). If the result is non-negative, keep it and set the quotient LSB to 1.
- The counter increments every CALC cycle. At counter==WIDTH-1: state=FIX.
- FIX (one cycle), result write:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write HI=upper/remainder and LO=lower/quotient; state=IDLE.
- Divide by zero, DIV or DIVU: LO=0xFFFFFFFF, HI=A (raw dividend), still after full latency.
- INT_MIN/−1 (DIV): LO=0x80000000, HI=0.

## Timing
- EN sampled at the edge ending cycle n: BUSY=1 in cycles n+1..n+33 (32 CALC + 1 FIX). HI/LO hold new values and BUSY=0 from cycle n+34.
- MTHI/MTLO: HI/LO update at the edge ending the EN cycle; BUSY=0 the next cycle.
- HI/LO are stable while BUSY=1, except for a direct MTHI/MTLO.
- A restart in CALC or FIX restarts the full 33-cycle latency from the new EN.

## Test plan
- Reset mid-CALC (RESET_N low for 1 cycle at cycle n+10) -> HI=LO=0 and BUSY=0 immediately; no later write occurs.
- MULTU with A=B=0xFFFFFFFF -> BUSY high exactly 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001.
- MULT with A=−3 (0xFFFFFFFD), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Divides:
  - DIV with A=−7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU with A=100, B=0 -> LO=0xFFFFFFFF, HI=100.
  - DIV with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULTU 6×7 launched, then DIVU 100/7 launched at cycle n+5 -> no write from the first op; BUSY falls at n+39; then LO=14, HI=2.
- MULT launched, then MTLO A=0x1234 at n+3 -> LO=0x1234 at n+4 with BUSY=0 and HI unchanged. Separately, KILL at n+20 -> BUSY=0 at n+21 and HI/LO unchanged.
